// File: rtl/jump_pkg.sv
// -----------------------------------------------------------------------------
// jump_pkg
// Shared definitions for the jump game logic and the VGA display block:
//   - state_t      : 4-bit FSM state encoding (also driven out on `state`)
//   - COLOR_*      : 2-bit stage colour codes
//   - geometry     : ground line, body height, home x, screen size
//   - motion       : jump length, launch speed, scroll and drop steps
//   - reset scene  : man and stage geometry loaded on reset / restart
//   - helpers      : saturating arithmetic used by the datapath
// -----------------------------------------------------------------------------
package jump_pkg;

   typedef enum logic [3:0] {
      ST_START  = 4'd0,
      ST_IDLE   = 4'd1,
      ST_CHARGE = 4'd2,
      ST_JUMP   = 4'd3,
      ST_LAND   = 4'd4,
      ST_SCROLL = 4'd5,
      ST_DROP   = 4'd6,
      ST_DEAD   = 4'd7
   } state_t;

   localparam logic [1:0] COLOR_GREEN  = 2'd0;
   localparam logic [1:0] COLOR_BLUE   = 2'd1;
   localparam logic [1:0] COLOR_YELLOW = 2'd2;
   localparam logic [1:0] COLOR_RED    = 2'd3;

   localparam logic [9:0] SCREEN_W  = 10'd800;
   localparam logic [9:0] SCREEN_H  = 10'd600;
   localparam logic [9:0] GROUND_Y  = 10'd500;
   localparam logic [9:0] TALL      = 10'd40;
   localparam logic [9:0] HOME_X    = 10'd200;
   localparam logic [9:0] MAN_X_MAX = SCREEN_W - 10'd1;

   localparam logic [4:0]        JUMP_TICKS  = 5'd31;
   localparam logic signed [5:0] VY0         = 6'sd15;
   localparam logic [9:0]        SCROLL_STEP = 10'd8;
   localparam logic [9:0]        DROP_STEP   = 10'd20;
   localparam logic [5:0]        POWER_MAX   = 6'd63;
   localparam logic [9:0]        CENTER_TOL  = 10'd4;

   // New stage1 placement offsets applied to LFSR bits
   localparam logic [9:0] NEW_X_BASE = 10'd400;
   localparam logic [9:0] NEW_W_BASE = 10'd20;

   localparam logic [9:0] RST_MAN_X    = 10'd200;
   localparam logic [9:0] RST_STAGE_X0 = 10'd200;
   localparam logic [9:0] RST_STAGE_X1 = 10'd500;
   localparam logic [9:0] RST_STAGE_W0 = 10'd60;
   localparam logic [9:0] RST_STAGE_W1 = 10'd40;
   localparam logic [9:0] LFSR_SEED    = 10'h1A5;

   // a - b, floored at zero
   function automatic logic [9:0] sat_sub10(input logic [9:0] a, input logic [9:0] b);
      if (a > b) begin
         return a - b;
      end else begin
         return 10'd0;
      end
   endfunction

   // a + b, capped at 255
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[8]) begin
         return 8'hFF;
      end else begin
         return sum[7:0];
      end
   endfunction

   // smaller of two 10-bit values
   function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
      if (a < b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/stage_lfsr.sv
// -----------------------------------------------------------------------------
// stage_lfsr
// 10-bit Fibonacci LFSR (x^10 + x^7 + 1) that picks the next stage geometry.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (loads LFSR_SEED)
//   step       : advance the register by one position this cycle
//   lfsr_next  : value the register takes on the next step; the caller uses
//                it in the same cycle it asserts step
// -----------------------------------------------------------------------------
module stage_lfsr
   import jump_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   output logic [9:0] lfsr_next
);

   logic [9:0] lfsr_r;
   logic [9:0] next_s;

   // feedback from taps 10 and 7, shifted in at the bottom
   always_comb begin
      next_s = {lfsr_r[8:0], lfsr_r[9] ^ lfsr_r[6]};
   end

   // shift register, advances only on step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_r <= LFSR_SEED;
      end else if (step) begin
         lfsr_r <= next_s;
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

   assign lfsr_next = next_s;

endmodule

// File: rtl/jump_engine.sv
// -----------------------------------------------------------------------------
// jump_engine
// Game-logic stage feeding the VGA display: button charge, ballistic jump,
// landing check, scroll and drop-in of a new stage. Motion advances once per
// frame_tick; button edges act on any cycle. All outputs are registered.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   frame_tick        : one-cycle pulse per video frame
//   btn               : raw button, double-flop synchronised here
//   man_x, man_y      : man bottom-centre position
//   man_tall          : man body height (squashes while charging)
//   stage_x[0:1]      : stage bottom-centre x
//   stage_w[0:1]      : stage half-width
//   stage_color[0:1]  : stage colour code
//   stage_y2          : stage1 top y (animated during drop-in)
//   state             : current FSM state (state_t encoding)
//   score             : successful landings, saturating at 255
// Build option:
//   JUMP_CENTER_BONUS_EN : a stage1 landing within 4 px of its centre scores 2
// -----------------------------------------------------------------------------
module jump_engine
   import jump_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       btn,
   output logic [9:0] man_x,
   output logic [9:0] man_y,
   output logic [9:0] man_tall,
   output logic [9:0] stage_x [0:1],
   output logic [9:0] stage_w [0:1],
   output logic [1:0] stage_color [0:1],
   output logic [9:0] stage_y2,
   output logic [3:0] state,
   output logic [7:0] score
);

   // button synchroniser and edge detect
   logic btn_meta_r, btn_sync_r, btn_prev_r;
   logic press_s, release_s;

   // architectural state
   state_t            state_r, state_nxt_s;
   logic [5:0]        power_r, power_nxt_s;
   logic [3:0]        vx_r, vx_nxt_s;
   logic signed [5:0] vy_r, vy_nxt_s;
   logic [9:0]        h_r, h_nxt_s;
   logic [4:0]        jcnt_r, jcnt_nxt_s;
   logic [9:0]        man_x_r, man_x_nxt_s;
   logic [9:0]        man_y_r, man_y_nxt_s;
   logic [9:0]        tall_r, tall_nxt_s;
   logic [9:0]        x0_r, x0_nxt_s, x1_r, x1_nxt_s;
   logic [9:0]        w0_r, w0_nxt_s, w1_r, w1_nxt_s;
   logic [1:0]        c0_r, c0_nxt_s, c1_r, c1_nxt_s;
   logic [9:0]        y2_r, y2_nxt_s;
   logic [7:0]        score_r, score_nxt_s;

   // LFSR interface
   logic       lfsr_step_s;
   logic [9:0] lfsr_next_s;

   // datapath helpers
   logic [5:0]  power_inc_s;
   logic [9:0]  tall_charge_s;
   logic [10:0] man_x_sum_s;
   logic [9:0]  man_x_jump_s;
   logic [9:0]  h_add_s;
   logic [4:0]  jcnt_inc_s;
   logic [9:0]  scroll_d_s;
   logic [9:0]  x1_scroll_s;
   logic [10:0] y2_sum_s;
   logic [9:0]  y2_drop_s;
   logic [9:0]  lo0_s, lo1_s;
   logic [10:0] hi0_s, hi1_s;
   logic        on_stage0_s, on_stage1_s;
   logic [7:0]  land_gain_s;

   stage_lfsr u_stage_lfsr (
      .clk       (clk),
      .rst       (rst),
      .step      (lfsr_step_s),
      .lfsr_next (lfsr_next_s)
   );

   // two-flop synchroniser plus previous-value flop for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_meta_r <= 1'b0;
         btn_sync_r <= 1'b0;
         btn_prev_r <= 1'b0;
      end else begin
         btn_meta_r <= btn;
         btn_sync_r <= btn_meta_r;
         btn_prev_r <= btn_sync_r;
      end
   end

   assign press_s   = btn_sync_r & ~btn_prev_r;
   assign release_s = ~btn_sync_r;

   // per-state arithmetic shared by the next-state logic
   always_comb begin
      power_inc_s   = (power_r == POWER_MAX) ? power_r : power_r + 6'd1;
      // squash uses the power value being written this tick
      tall_charge_s = TALL - {5'd0, power_inc_s[5:1]};
      man_x_sum_s   = {1'b0, man_x_r} + {7'd0, vx_r};
      man_x_jump_s  = (man_x_sum_s > {1'b0, MAN_X_MAX}) ? MAN_X_MAX : man_x_sum_s[9:0];
      h_add_s       = h_r + {{4{vy_r[5]}}, vy_r};
      jcnt_inc_s    = jcnt_r + 5'd1;
      scroll_d_s    = min10(SCROLL_STEP, sat_sub10(x1_r, HOME_X));
      x1_scroll_s   = sat_sub10(x1_r, scroll_d_s);
      y2_sum_s      = {1'b0, y2_r} + {1'b0, DROP_STEP};
      y2_drop_s     = (y2_sum_s >= {1'b0, GROUND_Y}) ? GROUND_Y : y2_sum_s[9:0];
   end

   // inclusive landing windows, left edges floored at zero
   always_comb begin
      lo0_s       = sat_sub10(x0_r, w0_r);
      lo1_s       = sat_sub10(x1_r, w1_r);
      hi0_s       = {1'b0, x0_r} + {1'b0, w0_r};
      hi1_s       = {1'b0, x1_r} + {1'b0, w1_r};
      on_stage0_s = (man_x_r >= lo0_s) && ({1'b0, man_x_r} <= hi0_s);
      on_stage1_s = (man_x_r >= lo1_s) && ({1'b0, man_x_r} <= hi1_s);
   end

`ifdef JUMP_CENTER_BONUS_EN
   logic [9:0] center_dist_s;

   // distance of the feet from stage1 centre decides the bonus
   always_comb begin
      if (man_x_r >= x1_r) begin
         center_dist_s = man_x_r - x1_r;
      end else begin
         center_dist_s = x1_r - man_x_r;
      end
      land_gain_s = (center_dist_s <= CENTER_TOL) ? 8'd2 : 8'd1;
   end
`else
   assign land_gain_s = 8'd1;
`endif

   // next-state and next-datapath logic
   always_comb begin
      state_nxt_s = state_r;
      power_nxt_s = power_r;
      vx_nxt_s    = vx_r;
      vy_nxt_s    = vy_r;
      h_nxt_s     = h_r;
      jcnt_nxt_s  = jcnt_r;
      man_x_nxt_s = man_x_r;
      man_y_nxt_s = man_y_r;
      tall_nxt_s  = tall_r;
      x0_nxt_s    = x0_r;
      x1_nxt_s    = x1_r;
      w0_nxt_s    = w0_r;
      w1_nxt_s    = w1_r;
      c0_nxt_s    = c0_r;
      c1_nxt_s    = c1_r;
      y2_nxt_s    = y2_r;
      score_nxt_s = score_r;
      lfsr_step_s = 1'b0;

      case (state_r)
         ST_START: begin
            if (press_s) begin
               man_x_nxt_s = RST_MAN_X;
               man_y_nxt_s = GROUND_Y;
               tall_nxt_s  = TALL;
               x0_nxt_s    = RST_STAGE_X0;
               x1_nxt_s    = RST_STAGE_X1;
               w0_nxt_s    = RST_STAGE_W0;
               w1_nxt_s    = RST_STAGE_W1;
               c0_nxt_s    = COLOR_GREEN;
               c1_nxt_s    = COLOR_RED;
               y2_nxt_s    = GROUND_Y;
               score_nxt_s = 8'd0;
               power_nxt_s = 6'd0;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_START;
            end
         end

         ST_IDLE: begin
            if (press_s) begin
               power_nxt_s = 6'd0;
               state_nxt_s = ST_CHARGE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end

         ST_CHARGE: begin
            // release takes priority over a coincident tick
            if (release_s) begin
               vx_nxt_s    = power_r[5:2];
               vy_nxt_s    = VY0;
               h_nxt_s     = 10'd0;
               jcnt_nxt_s  = 5'd0;
               tall_nxt_s  = TALL;
               state_nxt_s = ST_JUMP;
            end else if (frame_tick) begin
               power_nxt_s = power_inc_s;
               tall_nxt_s  = tall_charge_s;
            end else begin
               state_nxt_s = ST_CHARGE;
            end
         end

         ST_JUMP: begin
            if (frame_tick) begin
               man_x_nxt_s = man_x_jump_s;
               vy_nxt_s    = vy_r - 6'sd1;
               jcnt_nxt_s  = jcnt_inc_s;
               // pin the final height so rounding can never leave feet off ground
               if (jcnt_inc_s == JUMP_TICKS) begin
                  h_nxt_s     = 10'd0;
                  man_y_nxt_s = GROUND_Y;
                  state_nxt_s = ST_LAND;
               end else begin
                  h_nxt_s     = h_add_s;
                  man_y_nxt_s = GROUND_Y - h_add_s;
               end
            end else begin
               state_nxt_s = ST_JUMP;
            end
         end

         ST_LAND: begin
            if (on_stage1_s) begin
               score_nxt_s = sat_add8(score_r, land_gain_s);
               state_nxt_s = ST_SCROLL;
            end else if (on_stage0_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DEAD;
            end
         end

         ST_SCROLL: begin
            if (frame_tick) begin
               man_x_nxt_s = sat_sub10(man_x_r, scroll_d_s);
               x0_nxt_s    = sat_sub10(x0_r, scroll_d_s);
               // once stage1 is home it becomes stage0 and a new stage1 spawns
               if (x1_scroll_s == HOME_X) begin
                  x0_nxt_s    = x1_scroll_s;
                  w0_nxt_s    = w1_r;
                  c0_nxt_s    = c1_r;
                  lfsr_step_s = 1'b1;
                  x1_nxt_s    = NEW_X_BASE + {2'd0, lfsr_next_s[7:0]};
                  w1_nxt_s    = NEW_W_BASE + {5'd0, lfsr_next_s[4:0]};
                  c1_nxt_s    = lfsr_next_s[9:8];
                  y2_nxt_s    = 10'd0;
                  state_nxt_s = ST_DROP;
               end else begin
                  x1_nxt_s    = x1_scroll_s;
               end
            end else begin
               state_nxt_s = ST_SCROLL;
            end
         end

         ST_DROP: begin
            if (frame_tick) begin
               y2_nxt_s = y2_drop_s;
               if (y2_drop_s == GROUND_Y) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_DROP;
               end
            end else begin
               state_nxt_s = ST_DROP;
            end
         end

         ST_DEAD: begin
            if (press_s) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_DEAD;
            end
         end

         default: begin
            state_nxt_s = ST_START;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_START;
         power_r <= 6'd0;
         vx_r    <= 4'd0;
         vy_r    <= 6'sd0;
         h_r     <= 10'd0;
         jcnt_r  <= 5'd0;
         man_x_r <= RST_MAN_X;
         man_y_r <= GROUND_Y;
         tall_r  <= TALL;
         x0_r    <= RST_STAGE_X0;
         x1_r    <= RST_STAGE_X1;
         w0_r    <= RST_STAGE_W0;
         w1_r    <= RST_STAGE_W1;
         c0_r    <= COLOR_GREEN;
         c1_r    <= COLOR_RED;
         y2_r    <= GROUND_Y;
         score_r <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         power_r <= power_nxt_s;
         vx_r    <= vx_nxt_s;
         vy_r    <= vy_nxt_s;
         h_r     <= h_nxt_s;
         jcnt_r  <= jcnt_nxt_s;
         man_x_r <= man_x_nxt_s;
         man_y_r <= man_y_nxt_s;
         tall_r  <= tall_nxt_s;
         x0_r    <= x0_nxt_s;
         x1_r    <= x1_nxt_s;
         w0_r    <= w0_nxt_s;
         w1_r    <= w1_nxt_s;
         c0_r    <= c0_nxt_s;
         c1_r    <= c1_nxt_s;
         y2_r    <= y2_nxt_s;
         score_r <= score_nxt_s;
      end
   end

   assign man_x          = man_x_r;
   assign man_y          = man_y_r;
   assign man_tall       = tall_r;
   assign stage_x[0]     = x0_r;
   assign stage_x[1]     = x1_r;
   assign stage_w[0]     = w0_r;
   assign stage_w[1]     = w1_r;
   assign stage_color[0] = c0_r;
   assign stage_color[1] = c1_r;
   assign stage_y2       = y2_r;
   assign state          = state_r;
   assign score          = score_r;

endmodule
